// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module : mem_arb_pkg
// Shared types and constants for the two-port RAM access controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    localparam int ADDR_W_DEF = 7;
    localparam int DATA_W_DEF = 8;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_arb_pick.sv
// ============================================================================
// Module : mem_arb_pick
// Combinational two-way picker. Defining MEM_ARB_FIXED_PRI_EN makes port A
// win every contention and removes the pointer input.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
`ifndef MEM_ARB_FIXED_PRI_EN
    input  logic pointer,
`endif
    output logic valid,
    output logic winner
);

    assign valid = req_a | req_b;

`ifdef MEM_ARB_FIXED_PRI_EN
    assign winner = req_a ? PORT_A : PORT_B;
`else
    // On contention the pointer decides; otherwise the lone requester wins.
    assign winner = (req_a && req_b) ? pointer :
                    (req_b ? PORT_B : PORT_A);
`endif

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module : mem_arbiter
// Two-port access controller for a negedge-clocked single-port RAM. One
// transaction every three cycles; MEM_ARB_FIXED_PRI_EN selects fixed priority.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy,
    output logic              grant_b
);

    arb_state_t        r_state;
    logic              r_mem_cs;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_address;
    logic [DATA_W-1:0] r_mem_data_in;
    logic              r_a_ack;
    logic              r_b_ack;
    logic [DATA_W-1:0] r_a_rdata;
    logic [DATA_W-1:0] r_b_rdata;
    logic              r_busy;
    logic              r_grant_b;

    logic              w_valid;
    logic              w_winner;

`ifndef MEM_ARB_FIXED_PRI_EN
    logic              r_rr_ptr;
`endif

    mem_arb_pick u_pick (
        .req_a   (a_req),
        .req_b   (b_req),
`ifndef MEM_ARB_FIXED_PRI_EN
        .pointer (r_rr_ptr),
`endif
        .valid   (w_valid),
        .winner  (w_winner)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_mem_cs      <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_address <= '0;
            r_mem_data_in <= '0;
            r_a_ack       <= 1'b0;
            r_b_ack       <= 1'b0;
            r_a_rdata     <= '0;
            r_b_rdata     <= '0;
            r_busy        <= 1'b0;
            r_grant_b     <= PORT_A;
`ifndef MEM_ARB_FIXED_PRI_EN
            r_rr_ptr      <= PORT_A;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_mem_cs  <= 1'b1;
                        r_busy    <= 1'b1;
                        r_grant_b <= w_winner;
                        r_state   <= ST_ACCESS;
`ifndef MEM_ARB_FIXED_PRI_EN
                        r_rr_ptr  <= ~w_winner;
`endif
                        if (w_winner == PORT_B) begin
                            r_mem_we      <= b_we;
                            r_mem_address <= b_addr;
                            r_mem_data_in <= b_wdata;
                        end else begin
                            r_mem_we      <= a_we;
                            r_mem_address <= a_addr;
                            r_mem_data_in <= a_wdata;
                        end
                    end
                end

                ST_ACCESS: begin
                    // RAM acted on the negedge just passed; its read data is settled.
                    r_mem_cs <= 1'b0;
                    r_mem_we <= 1'b0;
                    r_state  <= ST_DONE;
                    if (r_grant_b == PORT_B) begin
                        r_b_ack <= 1'b1;
                        if (!r_mem_we) begin
                            r_b_rdata <= mem_data_out;
                        end
                    end else begin
                        r_a_ack <= 1'b1;
                        if (!r_mem_we) begin
                            r_a_rdata <= mem_data_out;
                        end
                    end
                end

                ST_DONE: begin
                    // Turnaround cycle: requests are not sampled here.
                    r_a_ack <= 1'b0;
                    r_b_ack <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state  <= ST_IDLE;
                    r_mem_cs <= 1'b0;
                    r_mem_we <= 1'b0;
                    r_a_ack  <= 1'b0;
                    r_b_ack  <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign mem_cs      = r_mem_cs;
    assign mem_we      = r_mem_we;
    assign mem_address = r_mem_address;
    assign mem_data_in = r_mem_data_in;
    assign a_ack       = r_a_ack;
    assign b_ack       = r_b_ack;
    assign a_rdata     = r_a_rdata;
    assign b_rdata     = r_b_rdata;
    assign busy        = r_busy;
    assign grant_b     = r_grant_b;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module : tb_mem_arbiter
// Directed self-checking bench for mem_arbiter with a behavioural 128x8 RAM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       a_req = 1'b0, a_we = 1'b0;
    logic [6:0] a_addr = '0;
    logic [7:0] a_wdata = '0;
    logic       b_req = 1'b0, b_we = 1'b0;
    logic [6:0] b_addr = '0;
    logic [7:0] b_wdata = '0;
    logic       a_ack, b_ack, mem_cs, mem_we, busy, grant_b;
    logic [7:0] a_rdata, b_rdata, mem_data_in;
    logic [6:0] mem_address;
    logic [7:0] mem_data_out = '0;

    logic [7:0] ram [0:127];

    int n_total = 0;
    int n_bad   = 0;

    always #5 clock = ~clock;

    mem_arbiter dut (
        .clock        (clock),
        .reset        (reset),
        .a_req        (a_req),
        .a_we         (a_we),
        .a_addr       (a_addr),
        .a_wdata      (a_wdata),
        .a_ack        (a_ack),
        .a_rdata      (a_rdata),
        .b_req        (b_req),
        .b_we         (b_we),
        .b_addr       (b_addr),
        .b_wdata      (b_wdata),
        .b_ack        (b_ack),
        .b_rdata      (b_rdata),
        .mem_cs       (mem_cs),
        .mem_we       (mem_we),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .busy         (busy),
        .grant_b      (grant_b)
    );

    // Negedge RAM with registered read; contents preloaded with ~address.
    initial begin
        for (int i = 0; i < 128; i++) ram[i] = ~(8'(i));
    end

    always @(negedge clock) begin
        if (mem_cs) begin
            if (mem_we) ram[mem_address] <= mem_data_in;
            else        mem_data_out     <= ram[mem_address];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // One full transaction: returns cycles from request to ack, leaves bus idle.
    task automatic txn(input logic port_b, input logic we, input logic [6:0] addr,
                       input logic [7:0] wdata, output int lat);
        logic ack_seen;
        if (port_b) begin
            b_we = we; b_addr = addr; b_wdata = wdata; b_req = 1'b1;
        end else begin
            a_we = we; a_addr = addr; a_wdata = wdata; a_req = 1'b1;
        end
        lat = 0;
        ack_seen = 1'b0;
        while (!ack_seen && lat < 10) begin
            step();
            lat++;
            ack_seen = port_b ? b_ack : a_ack;
        end
        if (!ack_seen) check("txn_timeout", 32'(ack_seen), 32'd1);
        a_req = 1'b0;
        b_req = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int na, nb;
        logic first_b;

        step();
        step();
        // Reset state
        check("rst_cs",      32'(mem_cs),      32'd0);
        check("rst_we",      32'(mem_we),      32'd0);
        check("rst_addr",    32'(mem_address), 32'd0);
        check("rst_din",     32'(mem_data_in), 32'd0);
        check("rst_ack",     32'({a_ack, b_ack}), 32'd0);
        check("rst_rdata",   32'({a_rdata, b_rdata}), 32'd0);
        check("rst_busy",    32'(busy),        32'd0);
        check("rst_grant",   32'(grant_b),     32'd0);
        reset = 1'b0;

        // A writes 0x5A to 0x10
        a_we = 1'b1; a_addr = 7'h10; a_wdata = 8'h5A; a_req = 1'b1;
        step();
        check("w_cs",    32'(mem_cs),      32'd1);
        check("w_we",    32'(mem_we),      32'd1);
        check("w_addr",  32'(mem_address), 32'h10);
        check("w_din",   32'(mem_data_in), 32'h5A);
        check("w_grant", 32'(grant_b),     32'd0);
        check("w_busy0", 32'(busy),        32'd1);
        check("w_ack0",  32'(a_ack),       32'd0);
        step();
        check("w_ack1",  32'(a_ack),       32'd1);
        check("w_back",  32'(b_ack),       32'd0);
        check("w_cs1",   32'(mem_cs),      32'd0);
        check("w_busy1", 32'(busy),        32'd1);
        a_req = 1'b0;
        step();
        check("w_ack2",  32'(a_ack),       32'd0);
        check("w_busy2", 32'(busy),        32'd0);
        check("w_hold_addr", 32'(mem_address), 32'h10);

        // B reads 0x10
        txn(1'b1, 1'b0, 7'h10, 8'h00, lat);
        check("rb_lat",   32'(lat),     32'd2);
        check("rb_rdata", 32'(b_rdata), 32'h5A);
        check("rb_ardata", 32'(a_rdata), 32'h00);

        // Simultaneous reads from reset: A first, B three cycles later
        do_reset();
        a_we = 1'b0; a_addr = 7'h01; a_req = 1'b1;
        b_we = 1'b0; b_addr = 7'h02; b_req = 1'b1;
        step();
        check("c_grant_a", 32'(grant_b),     32'd0);
        check("c_addr_a",  32'(mem_address), 32'h01);
        step();
        check("c_ack_a",   32'({a_ack, b_ack}), 32'b10);
        check("c_rdata_a", 32'(a_rdata),     32'hFE);
        a_req = 1'b0;
        step();
        check("c_done_cs", 32'(mem_cs),      32'd0);
        step();
        check("c_grant_b", 32'(grant_b),     32'd1);
        check("c_addr_b",  32'(mem_address), 32'h02);
        check("c_cs_b",    32'(mem_cs),      32'd1);
        step();
        check("c_ack_b",   32'({a_ack, b_ack}), 32'b01);
        check("c_rdata_b", 32'(b_rdata),     32'hFD);
        b_req = 1'b0;
        step();

        // Both held continuously for 12 cycles
        do_reset();
        a_we = 1'b0; a_addr = 7'h03; a_req = 1'b1;
        b_we = 1'b0; b_addr = 7'h04; b_req = 1'b1;
        na = 0; nb = 0; first_b = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (a_ack && na == 0 && nb == 0) first_b = 1'b0;
            if (a_ack) na++;
            if (b_ack) nb++;
        end
        a_req = 1'b0; b_req = 1'b0;
        step(); step(); step();
        check("hold_first_a", 32'(first_b), 32'd0);
`ifdef MEM_ARB_FIXED_PRI_EN
        check("hold_a_acks", 32'(na), 32'd4);
        check("hold_b_acks", 32'(nb), 32'd0);
`else
        check("hold_a_acks", 32'(na), 32'd2);
        check("hold_b_acks", 32'(nb), 32'd2);
`endif

        // Address extremes
        txn(1'b0, 1'b1, 7'h7F, 8'hFF, lat);
        check("x_lat", 32'(lat), 32'd2);
        txn(1'b0, 1'b0, 7'h7F, 8'h00, lat);
        check("x_rd7f", 32'(a_rdata), 32'hFF);
        txn(1'b0, 1'b1, 7'h00, 8'h11, lat);
        txn(1'b0, 1'b0, 7'h00, 8'h00, lat);
        check("x_rd00", 32'(a_rdata), 32'h11);
        txn(1'b0, 1'b0, 7'h7F, 8'h00, lat);
        check("x_rd7f_again", 32'(a_rdata), 32'hFF);

        // Reset during ACCESS of an A write
        a_we = 1'b1; a_addr = 7'h20; a_wdata = 8'h33; a_req = 1'b1;
        step();
        check("ra_cs", 32'(mem_cs), 32'd1);
        reset = 1'b1;
        step();
        check("ra_ack",   32'({a_ack, b_ack}), 32'd0);
        check("ra_cs0",   32'(mem_cs),      32'd0);
        check("ra_addr",  32'(mem_address), 32'd0);
        check("ra_din",   32'(mem_data_in), 32'd0);
        check("ra_busy",  32'(busy),        32'd0);
        check("ra_rdata", 32'({a_rdata, b_rdata}), 32'd0);
        reset = 1'b0; a_req = 1'b0;
        step();
        check("ra_no_ack", 32'(a_ack), 32'd0);
        txn(1'b1, 1'b0, 7'h20, 8'h00, lat);
        check("ra_rd20", 32'(b_rdata), 32'h33);

        // B raises req while A's read is in flight; must wait for IDLE
        a_we = 1'b0; a_addr = 7'h05; a_req = 1'b1;
        step();
        check("t_busy0", 32'(busy), 32'd1);
        b_we = 1'b0; b_addr = 7'h06; b_req = 1'b1;
        step();
        check("t_ack_a",  32'(a_ack),   32'd1);
        check("t_rdata_a", 32'(a_rdata), 32'hFA);
        check("t_busy1",  32'(busy),    32'd1);
        a_req = 1'b0;
        step();
        check("t_done_cs",   32'(mem_cs), 32'd0);
        check("t_done_busy", 32'(busy),   32'd0);
        step();
        check("t_cs_b",    32'(mem_cs),      32'd1);
        check("t_grant_b", 32'(grant_b),     32'd1);
        check("t_addr_b",  32'(mem_address), 32'h06);
        step();
        check("t_ack_b",   32'(b_ack),   32'd1);
        check("t_rdata_b", 32'(b_rdata), 32'hF9);
        b_req = 1'b0;
        step();
        check("t_end_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port access controller for the 128 x 8 single-port data RAM (cs/we/address/data_in/data_out, negedge-clocked, registered read). It accepts independent read/write requests from port A (CPU) and port B (secondary master, e.g. display/DMA), grants one at a time, sequences the RAM command, and returns read data with a one-cycle ack pulse. It sits directly between the requesters and the RAM instance; no other block drives the RAM.

## Interface
- ADDR_W, 7, RAM address width (128 words)
- DATA_W, 8, RAM data width
- clock  in  1  system clock; all controller state changes on posedge
- reset  in  1  synchronous, active-high
- a_req, b_req  in  1  request; held high until matching ack
- a_we, b_we  in  1  1 = write, 0 = read; stable while req high
- a_addr, b_addr  in  ADDR_W  word address; stable while req high
- a_wdata, b_wdata  in  DATA_W  write data; stable while req high
- a_ack, b_ack  out  1  one-cycle completion pulse
- a_rdata, b_rdata  out  DATA_W  read result; valid from ack until that port's next read completes
- mem_cs, mem_we  out  1  RAM chip select / write enable (registered)
- mem_address  out  ADDR_W  RAM address (registered)
- mem_data_in  out  DATA_W  RAM write data (registered)
- mem_data_out  in  DATA_W  RAM registered read data
- busy  out  1  high in ACCESS and DONE
- grant_b  out  1  0 = port A owns current/last transaction, 1 = port B

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: no req -> stay, mem_cs=0. Any req -> arbitrate, register mem_cs=1, mem_we, mem_address, mem_data_in from the winner, grant_b, -> ACCESS.
- ACCESS: RAM executes on the intervening negedge. Next posedge: mem_cs/mem_we <= 0; winner's ack <= 1; on read, winner's rdata <= mem_data_out; on write, rdata unchanged; -> DONE.
- DONE: ack <= 0; req ignored (turnaround so requester can drop/update req); -> IDLE.
- Arbitration (default): round-robin; pointer names the port preferred on contention; after a grant it points to the other port. Single requester always wins.
- Loser's req stays pending, no ack, inputs must remain stable.
- mem_address/mem_data_in hold last values when mem_cs=0.
- Requester violating hold rules (dropping req before ack): transaction already in ACCESS still completes and acks.

## Timing
- Reset values: state IDLE, mem_cs 0, mem_we 0, mem_address 0, mem_data_in 0, a/b_ack 0, a/b_rdata 0, busy 0, grant_b 0, RR pointer = A.
- Transaction: req sampled at edge E0 -> mem_cs high E0..E1 -> ack high E1..E2 -> IDLE from E2 -> next req sampled at E3. Fixed 3-cycle throughput, ack latency 1 cycle after grant edge.
- Back-to-back contention: A and B both held high -> grants alternate A,B,A,... every 3 cycles.
- Reset sampled at E0: no RAM command issued. Reset sampled at E1 (in ACCESS): RAM operation already performed at the negedge (write lands), but no ack, rdata not updated, all outputs to reset values.
- RAM contents never cleared by reset.

## Configuration
- MEM_ARB_FIXED_PRI_EN defined: port A always wins contention; RR pointer removed; B served only when a_req low in IDLE.
- Undefined (default): round-robin as above.

## Structure
- Package mem_arb_pkg: state encoding (IDLE/ACCESS/DONE), ADDR_W/DATA_W defaults, port index constants PORT_A=0, PORT_B=1.
- Sub-module mem_arb_pick: combinational 2-way picker (req_a, req_b, pointer -> winner), with the macro selecting fixed-priority form inside it; FSM and registers stay in mem_arbiter.

## Test plan
- Reset, then A writes 0x5A to addr 0x10 -> mem_cs/mem_we high one cycle, address 0x10, data 0x5A; a_ack pulse at E1; b_ack stays 0.
- B reads addr 0x10 after above -> b_ack pulse, b_rdata = 0x5A; a_rdata remains 0x00.
- A and B both request reads (A addr 0x01, B addr 0x02) from reset -> A granted first, B granted 3 cycles later; with MEM_ARB_FIXED_PRI_EN and a_req held continuously, B never acked.
- Write addr 0x7F = 0xFF, read 0x7F, write 0x00 = 0x11, read 0x00 -> rdata 0xFF then 0x11 (address extremes, no wrap aliasing).
- Reset asserted during ACCESS of A write 0x33 to 0x20 -> no ack, outputs at reset values next cycle; subsequent B read of 0x20 returns 0x33.
- A reads 0x05 while B holds req across A's DONE cycle -> B not granted until IDLE at E2, sampled E3; busy high exactly 2 cycles per transaction.
